// File: rtl/window_coef_sequencer.sv
// Window coefficient sequencer: walks the window-function generator through
// indices 0..n-1, one single-shot trigger per index, and streams each
// captured coefficient with its index over a valid/ready interface.
module window_coef_sequencer #(
  parameter int MAX_LGN = 12,
  parameter int TRIG_TO = 16,
  parameter int GAP_MIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  win_type_cfg,
  input  logic [7:0]  lgn_cfg,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        gen_en,
  output logic [3:0]  gen_win_type,
  output logic [15:0] gen_n,
  output logic [15:0] gen_i,
  output logic [7:0]  gen_lgn,
  input  logic        gen_busy,
  input  logic [15:0] gen_win,
  output logic        coef_valid,
  input  logic        coef_ready,
  output logic [15:0] coef_idx,
  output logic [15:0] coef_data
);

  localparam int GW = (GAP_MIN < 2) ? 1 : $clog2(GAP_MIN + 1);
  localparam int TW = $clog2(TRIG_TO + 1);
  localparam logic [GW-1:0] GAP_SAT   = GW'(GAP_MIN);
  localparam logic [TW-1:0] TO_LAST   = TW'(TRIG_TO - 1);
  localparam logic [7:0]    MAX_LGN_B = 8'(MAX_LGN);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_TRIG, S_WAIT_HI, S_WAIT_LO, S_OUT, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    EC_NONE    = 2'd0,
    EC_LGN     = 2'd1,
    EC_TIMEOUT = 2'd2,
    EC_ABORT   = 2'd3
  } err_code_t;

  state_t    state, state_n;
  err_code_t code_q, code_n;

  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;
  logic          abort_pend;

  logic ld_cfg, clr_i, inc_i, capture, code_ld;
  logic lgn_ok, hs, last, abort_eff;

  // Moore outputs decoded straight from the state.
  assign busy       = (state == S_GAP) || (state == S_TRIG) || (state == S_WAIT_HI) ||
                      (state == S_WAIT_LO) || (state == S_OUT);
  assign done       = (state == S_DONE);
  assign err        = (state == S_ERR);
  assign err_code   = err ? code_q : EC_NONE;
  assign gen_en     = (state == S_TRIG) || (state == S_WAIT_HI);
  assign coef_valid = (state == S_OUT);
  assign gen_n      = 16'd1 << gen_lgn;

  assign lgn_ok    = (lgn_cfg != 8'd0) && (lgn_cfg <= MAX_LGN_B);
  assign hs        = coef_valid && coef_ready;
  assign last      = (gen_i == gen_n - 16'd1);
  // An abort seen while the trigger is up is held until a state that may act on it.
  assign abort_eff = abort || abort_pend;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of block ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_n = state;
    ld_cfg  = 1'b0;
    clr_i   = 1'b0;
    inc_i   = 1'b0;
    capture = 1'b0;
    code_ld = 1'b0;
    code_n  = EC_NONE;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          ld_cfg = 1'b1;
          if (!lgn_ok) begin
            code_ld = 1'b1;
            code_n  = EC_LGN;
            state_n = S_ERR;
          end else begin
            clr_i   = 1'b1;
            state_n = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (abort_eff) begin
          code_ld = 1'b1;
          code_n  = EC_ABORT;
          state_n = S_ERR;
        end else if (gap_cnt >= GAP_SAT) begin
          state_n = S_TRIG;
        end
      end
      S_TRIG: state_n = S_WAIT_HI;
      S_WAIT_HI: begin
        if (gen_busy) begin
          state_n = S_WAIT_LO;
        end else if (to_cnt == TO_LAST) begin
          code_ld = 1'b1;
          code_n  = EC_TIMEOUT;
          state_n = S_ERR;
        end
      end
      S_WAIT_LO: begin
        if (abort_eff) begin
          code_ld = 1'b1;
          code_n  = EC_ABORT;
          state_n = S_ERR;
        end else if (!gen_busy) begin
          capture = 1'b1;
          state_n = S_OUT;
        end
      end
      S_OUT: begin
        // A handshake in progress always completes before an abort is honoured.
        if (hs) begin
          if (abort_eff) begin
            code_ld = 1'b1;
            code_n  = EC_ABORT;
            state_n = S_ERR;
          end else if (last) begin
            state_n = S_DONE;
          end else begin
            inc_i   = 1'b1;
            state_n = S_GAP;
          end
        end else if (abort_eff) begin
          code_ld = 1'b1;
          code_n  = EC_ABORT;
          state_n = S_ERR;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Gap counter (low cycles of gen_en, saturating) and trigger timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= GAP_SAT;
      to_cnt  <= '0;
    end else begin
      if (gen_en)                 gap_cnt <= '0;
      else if (gap_cnt < GAP_SAT) gap_cnt <= gap_cnt + GW'(1);
      // Zero during TRIG, so WAIT_HI sees 1..TRIG_TO-1 and gen_en stays up TRIG_TO cycles.
      if (gen_en) to_cnt <= to_cnt + TW'(1);
      else        to_cnt <= '0;
    end
  end

  // Deferred abort: remembered through TRIG/WAIT_HI, dropped once the run ends.
  always_ff @(posedge clk) begin
    if (rst)                                                     abort_pend <= 1'b0;
    else if ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR)) abort_pend <= 1'b0;
    else if (abort)                                              abort_pend <= 1'b1;
  end

  // Latched configuration, index counter, captured coefficient and error code.
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_win_type <= '0;
      gen_lgn      <= '0;
      gen_i        <= '0;
      coef_idx     <= '0;
      coef_data    <= '0;
      code_q       <= EC_NONE;
    end else begin
      if (ld_cfg) begin
        gen_win_type <= win_type_cfg;
        gen_lgn      <= lgn_cfg;
      end
      if (clr_i)      gen_i <= '0;
      else if (inc_i) gen_i <= gen_i + 16'd1;
      if (capture) begin
        coef_data <= gen_win;
        coef_idx  <= gen_i;
      end
      if (code_ld) code_q <= code_n;
    end
  end

endmodule

// File: tb/tb_window_coef_sequencer.sv
// Self-checking bench for window_coef_sequencer: behavioural generator model,
// consumer with selectable ready pattern, and an expected-coefficient queue.
module tb_window_coef_sequencer;

  localparam int MAX_LGN = 12;
  localparam int TRIG_TO = 16;
  localparam int GAP_MIN = 2;

  logic        clk;
  logic        rst, start, abort;
  logic [3:0]  win_type_cfg;
  logic [7:0]  lgn_cfg;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic        gen_en;
  logic [3:0]  gen_win_type;
  logic [15:0] gen_n, gen_i;
  logic [7:0]  gen_lgn;
  logic        gen_busy;
  logic [15:0] gen_win;
  logic        coef_valid, coef_ready;
  logic [15:0] coef_idx, coef_data;

  window_coef_sequencer #(.MAX_LGN(MAX_LGN), .TRIG_TO(TRIG_TO), .GAP_MIN(GAP_MIN)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .win_type_cfg(win_type_cfg), .lgn_cfg(lgn_cfg),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .gen_en(gen_en), .gen_win_type(gen_win_type), .gen_n(gen_n), .gen_i(gen_i),
    .gen_lgn(gen_lgn), .gen_busy(gen_busy), .gen_win(gen_win),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_idx(coef_idx), .coef_data(coef_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0] idx;
    logic [15:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Shared stimulus knobs (written by the main thread just after posedge).
  int win_mode   = 0;  // 0: constant 1.0, 1: index-dependent ramp
  int ready_mode = 1;  // 0: never ready, 1: always ready, 2: ready 1-of-3
  bit gen_dead   = 0;  // generator ignores triggers

  // Generator model state and observations.
  int en_rises = 0;
  int last_run = 0;
  int en_len   = 0;
  int low_cnt  = 100;
  bit en_prev  = 0;
  int phase    = 0;
  int hold     = 0;
  int hs_cnt   = 0;
  int rdy_ctr  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_win(input int mode, input logic [15:0] i);
    if (mode == 0) return 16'd256;
    return 16'(int'(i) * 37 - 100);
  endfunction

  // Generator: one latency cycle after the trigger rises, busy for three
  // cycles, then presents the window value for the current index.
  initial begin
    gen_busy = 1'b0;
    gen_win  = 16'd0;
    forever begin
      @(negedge clk);
      if (gen_en) begin
        if (!en_prev) begin
          en_rises++;
          check("gen_en_gap", 32'(low_cnt >= GAP_MIN), 32'd1);
          en_len = 0;
          if (!gen_dead) phase = 1;
        end
        en_len++;
        low_cnt = 0;
      end else begin
        if (en_prev) last_run = en_len;
        if (low_cnt < 1000) low_cnt++;
      end
      en_prev = gen_en;
      case (phase)
        1: phase = 2;
        2: begin gen_busy = 1'b1; hold = 2; phase = 3; end
        3: begin
          if (hold == 0) begin
            gen_busy = 1'b0;
            gen_win  = exp_win(win_mode, gen_i);
            phase    = 0;
          end else begin
            hold--;
          end
        end
        default: ;
      endcase
    end
  end

  // Consumer: chooses ready for the coming edge and scores every valid cycle.
  initial begin
    coef_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       coef_ready = 1'b0;
        1:       coef_ready = 1'b1;
        default: begin coef_ready = ((rdy_ctr % 3) == 0); rdy_ctr++; end
      endcase
      if (coef_valid) begin
        check("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          check("coef_idx", coef_idx, sb_q[0].idx);
          check("coef_data", coef_data, sb_q[0].data);
          if (coef_ready && !rst) begin
            void'(sb_q.pop_front());
            hs_cnt++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int lgn, input int mode);
    exp_t e;
    for (int i = 0; i < (1 << lgn); i++) begin
      e.idx  = 16'(i);
      e.data = exp_win(mode, 16'(i));
      sb_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [3:0] t, input logic [7:0] l);
    win_type_cfg = t;
    lgn_cfg      = l;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int k = 0;
    while (!(done || err) && k < budget) begin
      tick();
      k++;
    end
    check("end_seen", 32'(done | err), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!coef_valid && k < budget) begin
      tick();
      k++;
    end
    check("valid_seen", coef_valid, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_err_code"}, err_code, 2'd0);
    check({tag, "_gen_en"}, gen_en, 1'b0);
    check({tag, "_coef_valid"}, coef_valid, 1'b0);
    check({tag, "_gen_i"}, gen_i, 16'd0);
    check({tag, "_coef_idx"}, coef_idx, 16'd0);
    check({tag, "_coef_data"}, coef_data, 16'd0);
    check({tag, "_gen_win_type"}, gen_win_type, 4'd0);
    check({tag, "_gen_lgn"}, gen_lgn, 8'd0);
    check({tag, "_gen_n"}, gen_n, 16'd1);
  endtask

  // Full window run to completion; optionally pokes cfg and start mid-run.
  task automatic run_normal(input logic [3:0] t, input int l, input int mode,
                            input int rmode, input bit poke);
    int n  = 1 << l;
    int h0 = hs_cnt;
    win_mode   = mode;
    ready_mode = rmode;
    push_run(l, mode);
    pulse_start(t, 8'(l));
    check("run_busy", busy, 1'b1);
    check("run_type", gen_win_type, t);
    check("run_lgn", gen_lgn, 8'(l));
    check("run_n", gen_n, 16'(n));
    check("run_i0", gen_i, 16'd0);
    if (poke) begin
      repeat (7) tick();
      pulse_start(~t, 8'(l + 1));
      check("poke_busy", busy, 1'b1);
      check("poke_type", gen_win_type, t);
      check("poke_lgn", gen_lgn, 8'(l));
    end
    wait_end(40 * n + 40);
    check("run_done", done, 1'b1);
    check("run_err", err, 1'b0);
    check("run_busy_at_done", busy, 1'b0);
    check("run_handshakes", 32'(hs_cnt - h0), 32'(n));
    check("run_sb_empty", 32'(sb_q.size()), 32'd0);
    tick();
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    int rises0;
    int k;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    win_type_cfg = 4'd0; lgn_cfg = 8'd0;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    repeat (2) tick();
    check("idle_busy", busy, 1'b0);

    // lgn=3, constant 1.0, always ready, with ignored mid-run start and cfg change.
    run_normal(4'd1, 3, 0, 1, 1'b1);
    // lgn=2, ramp values, ready one cycle in three.
    run_normal(4'd4, 2, 1, 2, 1'b0);
    ready_mode = 1;

    // Invalid lengths, plus the largest legal one aborted while in GAP.
    rises0 = en_rises;
    pulse_start(4'd3, 8'd0);
    check("lgn0_err", err, 1'b1);
    check("lgn0_code", err_code, 2'd1);
    check("lgn0_busy", busy, 1'b0);
    tick();
    check("lgn0_err_clear", err, 1'b0);
    pulse_start(4'd3, 8'd13);
    check("lgn13_err", err, 1'b1);
    check("lgn13_code", err_code, 2'd1);
    check("lgn13_busy", busy, 1'b0);
    tick();
    pulse_start(4'd3, 8'd12);
    check("lgn12_busy", busy, 1'b1);
    check("lgn12_n", gen_n, 16'd4096);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("gap_abort_err", err, 1'b1);
    check("gap_abort_code", err_code, 2'd3);
    check("gap_abort_busy", busy, 1'b0);
    tick();
    check("no_trigger_on_errors", 32'(en_rises - rises0), 32'd0);

    // Dead generator: timeout wins over an abort raised during WAIT_HI.
    gen_dead = 1'b1;
    pulse_start(4'd2, 8'd1);
    k = 0;
    while (!gen_en && k < 20) begin tick(); k++; end
    check("to_trigger_seen", gen_en, 1'b1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_end(60);
    check("to_err", err, 1'b1);
    check("to_code", err_code, 2'd2);
    check("to_gen_en_low", gen_en, 1'b0);
    tick();
    check("to_en_high_cycles", 32'(last_run), 32'(TRIG_TO));
    gen_dead = 1'b0;
    repeat (2) tick();
    run_normal(4'd2, 1, 1, 1, 1'b0);

    // Abort while OUT stalls on ready.
    win_mode   = 0;
    ready_mode = 0;
    push_run(2, 0);
    pulse_start(4'd5, 8'd2);
    wait_valid(80);
    repeat (2) tick();
    check("stall_valid", coef_valid, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("out_abort_err", err, 1'b1);
    check("out_abort_code", err_code, 2'd3);
    check("out_abort_valid", coef_valid, 1'b0);
    check("out_abort_busy", busy, 1'b0);
    check("out_abort_left", 32'(sb_q.size()), 32'd4);
    sb_q.delete();
    tick();

    // Abort coincident with a handshake: the transfer still counts.
    push_run(2, 0);
    pulse_start(4'd5, 8'd2);
    wait_valid(80);
    k = hs_cnt;
    ready_mode = 1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("hs_abort_err", err, 1'b1);
    check("hs_abort_code", err_code, 2'd3);
    check("hs_abort_valid", coef_valid, 1'b0);
    check("hs_abort_counted", 32'(hs_cnt - k), 32'd1);
    check("hs_abort_left", 32'(sb_q.size()), 32'd3);
    sb_q.delete();
    tick();

    // Reset while waiting for the generator to finish.
    win_mode = 1;
    push_run(2, 1);
    pulse_start(4'd7, 8'd2);
    k = 0;
    while (!(busy && !gen_en && gen_busy) && k < 40) begin tick(); k++; end
    check("wait_lo_seen", 32'(busy && !gen_en && gen_busy), 32'd1);
    rst = 1'b1;
    tick();
    check_reset("midrun_reset");
    rst = 1'b0;
    sb_q.delete();
    repeat (8) tick();
    run_normal(4'd6, 1, 1, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
